regfile_wb_arbiter: RTL
=======================

Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port (wr_en/addr_d/data_d) among three writeback sources: ALU pipeline, LSU, MDU (mul/div).
- Holds a pending-write scoreboard for long-latency destinations (LSU/MDU) so decode can detect RAW/WAW hazards.
- Output stage is registered and drives the register file write port directly.

Parameters:
- ADDRW, 5, register address width (2^ADDRW registers; x0 hardwired zero).
- DATAW, 32, register data width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- alu_valid  in  1  ALU writeback request
- alu_ready  out  1  ALU request accepted this cycle
- alu_addr  in  ADDRW  ALU destination
- alu_data  in  DATAW  ALU result
- lsu_valid / lsu_ready / lsu_addr / lsu_data  in/out/in/in  1/1/ADDRW/DATAW  LSU writeback, same semantics
- mdu_valid / mdu_ready / mdu_addr / mdu_data  in/out/in/in  1/1/ADDRW/DATAW  MDU writeback, same semantics
- rf_wr_en  out  1  register file write enable (registered)
- rf_addr_d  out  ADDRW  register file write address (registered)
- rf_data_d  out  DATAW  register file write data (registered)
- iss_en  in  1  a long-latency op issued this cycle
- iss_addr  in  ADDRW  its destination
- chk_addr_a, chk_addr_b, chk_addr_d  in  ADDRW  decode source/destination addresses to check
- busy_a, busy_b, busy_d  out  1  scoreboard bit for the matching chk address (combinational from state; 0 for address 0)
- byp_valid  out  1  bypass: write in output stage valid
- byp_addr  out  ADDRW  bypass address
- byp_data  out  DATAW  bypass data

Behaviour:
- Handshake: transfer occurs when valid & ready in the same cycle. ready is combinational from the valids and the round-robin state. ready never depends on its own source's data.
- Arbitration: at most one ready per cycle.
  - alu_valid takes fixed top priority.
  - Otherwise LSU/MDU use round-robin; rr=0 prefers LSU, rr=1 prefers MDU.
  - rr flips to favour the other unit after any LSU or MDU grant.
  - With neither unit valid, rr holds.
  - Continuous alu_valid may starve LSU/MDU by design; the pipeline guarantees ALU bubbles.
- Output stage, 1-cycle latency. On the posedge after a transfer:
  - rf_wr_en=1, rf_addr_d/rf_data_d = the granted source's addr/data.
  - Transfer to address 0: accepted (ready=1) but rf_wr_en stays 0.
  - No transfer: rf_wr_en=0; addr/data hold their last value.
- Scoreboard: busy bit per register 1..2^ADDRW-1.
  - iss_en with iss_addr!=0 sets the bit.
  - An accepted LSU/MDU transfer clears the bit of its address.
  - ALU transfers never touch the scoreboard.
  - Set and clear of the same address in the same cycle: set wins.
  - Updates become visible on busy_* the cycle after the edge.
  - Issue to an already-busy register: bit stays 1; WAW avoidance uses busy_d at decode.
- Reset (asynchronous, any time including mid-transfer):
  - rf_wr_en=0, rf_addr_d=0, rf_data_d=0, all busy bits 0, rr=0, byp_* = 0.
  - In-flight writes are discarded.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined: byp_valid=rf_wr_en, byp_addr=rf_addr_d, byp_data=rf_data_d. Decode can forward the value being written this cycle (regfile read is asynchronous, write lands at the next edge).
- Undefined: byp_valid, byp_addr, byp_data tied to 0; no extra logic.

Test Plan:
- ALU only: alu_valid=1, addr=3, data=0x1234 -> alu_ready=1 same cycle; next cycle rf_wr_en=1, rf_addr_d=3, rf_data_d=0x1234.
- All three valid, rr=0 -> cycle0 ALU granted. ALU drops -> LSU granted, then MDU; rr toggles 0->1->0.
- Write to x0 from LSU: lsu_addr=0 -> lsu_ready=1, rf_wr_en stays 0, no busy change.
- Scoreboard:
  - iss_en addr 7 -> busy_a=1 for chk_addr_a=7.
  - MDU writes 7 -> busy clears the cycle after the writeback edge.
  - iss_en addr 7 in the same cycle as the MDU clear of 7 -> busy stays 1.
- Reset assertion mid-stream with rf_wr_en=1 and busy bits set -> immediately rf_wr_en=0, busy_*=0, rf_addr_d/rf_data_d=0.
- WB_BYPASS_EN defined: ALU write addr 5 data 0xABCD -> byp_valid=1, byp_addr=5, byp_data=0xABCD in the same cycle as rf_wr_en. Undefined: byp_* constant 0.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter: ALU/LSU/MDU share one registered write port, with a
// pending-write scoreboard for long-latency ops. Optional feature macro: WB_BYPASS_EN.
module regfile_wb_arbiter #(
  parameter int unsigned ADDRW = 5,
  parameter int unsigned DATAW = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             alu_valid_i,
  output logic             alu_ready_o,
  input  logic [ADDRW-1:0] alu_addr_i,
  input  logic [DATAW-1:0] alu_data_i,
  input  logic             lsu_valid_i,
  output logic             lsu_ready_o,
  input  logic [ADDRW-1:0] lsu_addr_i,
  input  logic [DATAW-1:0] lsu_data_i,
  input  logic             mdu_valid_i,
  output logic             mdu_ready_o,
  input  logic [ADDRW-1:0] mdu_addr_i,
  input  logic [DATAW-1:0] mdu_data_i,
  output logic             rf_wr_en_o,
  output logic [ADDRW-1:0] rf_addr_d_o,
  output logic [DATAW-1:0] rf_data_d_o,
  input  logic             iss_en_i,
  input  logic [ADDRW-1:0] iss_addr_i,
  input  logic [ADDRW-1:0] chk_addr_a_i,
  input  logic [ADDRW-1:0] chk_addr_b_i,
  input  logic [ADDRW-1:0] chk_addr_d_i,
  output logic             busy_a_o,
  output logic             busy_b_o,
  output logic             busy_d_o,
  output logic             byp_valid_o,
  output logic [ADDRW-1:0] byp_addr_o,
  output logic [DATAW-1:0] byp_data_o
);

  localparam int unsigned NumRegs = 1 << ADDRW;

  logic               alu_gnt, lsu_gnt, mdu_gnt;
  logic               rr_q, rr_d;
  logic               wr_en_q, wr_en_d;
  logic [ADDRW-1:0]   wr_addr_q, wr_addr_d;
  logic [DATAW-1:0]   wr_data_q, wr_data_d;
  logic [NumRegs-1:0] sb_q, sb_d;

  // ALU has fixed priority; rr_q breaks LSU/MDU ties (0 favours LSU).
  always_comb begin
    alu_gnt = alu_valid_i;
    lsu_gnt = !alu_valid_i && lsu_valid_i && (!mdu_valid_i || !rr_q);
    mdu_gnt = !alu_valid_i && mdu_valid_i && (!lsu_valid_i || rr_q);
  end

  assign alu_ready_o = alu_gnt;
  assign lsu_ready_o = lsu_gnt;
  assign mdu_ready_o = mdu_gnt;

  always_comb begin
    rr_d      = rr_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (lsu_gnt) rr_d = 1'b1;
    if (mdu_gnt) rr_d = 1'b0;
    // Writes to x0 are accepted but dropped; addr/data keep their last real write.
    if (alu_gnt && (alu_addr_i != '0)) begin
      wr_en_d   = 1'b1;
      wr_addr_d = alu_addr_i;
      wr_data_d = alu_data_i;
    end else if (lsu_gnt && (lsu_addr_i != '0)) begin
      wr_en_d   = 1'b1;
      wr_addr_d = lsu_addr_i;
      wr_data_d = lsu_data_i;
    end else if (mdu_gnt && (mdu_addr_i != '0)) begin
      wr_en_d   = 1'b1;
      wr_addr_d = mdu_addr_i;
      wr_data_d = mdu_data_i;
    end
  end

  // Clears applied first so a same-cycle issue to the same register wins.
  always_comb begin
    sb_d = sb_q;
    if (lsu_gnt) sb_d[lsu_addr_i] = 1'b0;
    if (mdu_gnt) sb_d[mdu_addr_i] = 1'b0;
    if (iss_en_i) sb_d[iss_addr_i] = 1'b1;
    sb_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q      <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      sb_q      <= '0;
    end else begin
      rr_q      <= rr_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      sb_q      <= sb_d;
    end
  end

  assign rf_wr_en_o  = wr_en_q;
  assign rf_addr_d_o = wr_addr_q;
  assign rf_data_d_o = wr_data_q;

  assign busy_a_o = sb_q[chk_addr_a_i];
  assign busy_b_o = sb_q[chk_addr_b_i];
  assign busy_d_o = sb_q[chk_addr_d_i];

`ifdef WB_BYPASS_EN
  assign byp_valid_o = wr_en_q;
  assign byp_addr_o  = wr_addr_q;
  assign byp_data_o  = wr_data_q;
`else
  assign byp_valid_o = 1'b0;
  assign byp_addr_o  = '0;
  assign byp_data_o  = '0;
`endif

endmodule
